// File: rtl/seven_segment_scan_decoder.sv
// rtl/seven_segment_scan_decoder.sv - multiplexed seven-segment readback decoder with frame confirmation
module seven_segment_scan_decoder #(
    parameter int SEGMENT_NUM      = 8,
    parameter int SEGMENT_NUM_USED = 4,
    parameter int STABLE_SAMPLES   = 4,
    parameter int FRAMES_TO_MATCH  = 2
) (
    input  logic                          i_Clk,
    input  logic                          i_Reset,
    input  logic [6:0]                    i_Segments,
    input  logic [SEGMENT_NUM-1:0]        i_Anodes,
    output logic [4*SEGMENT_NUM_USED-1:0] o_BCD_Num,
    output logic                          o_Valid,
    output logic                          o_Locked,
    output logic                          o_Frame_Error
);
    localparam int W  = SEGMENT_NUM + 7;
    localparam int NW = 4 * SEGMENT_NUM_USED;
    localparam int CW = $clog2(STABLE_SAMPLES + 1);
    localparam int MW = $clog2(FRAMES_TO_MATCH + 1);
    localparam int EW = (SEGMENT_NUM_USED > 1) ? $clog2(SEGMENT_NUM_USED) : 1;

    typedef enum logic {HUNT, COLLECT} state_t;

    logic [W-1:0]  sync1, sync2, prev;
    logic [CW-1:0] dwell_cnt;
    logic          same, capture;

    // Synchronizer and history reset to the blank pattern (all lines high).
    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
        end else begin
            sync1 <= {i_Anodes, i_Segments};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign same    = (sync2 == prev);
    assign capture = same && (dwell_cnt == CW'(STABLE_SAMPLES - 1));

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset)
            dwell_cnt <= '0;
        else if (!same)
            dwell_cnt <= CW'(1);
        else if (dwell_cnt != CW'(STABLE_SAMPLES))
            dwell_cnt <= dwell_cnt + CW'(1);
    end

    logic [SEGMENT_NUM-1:0] an;
    logic [6:0]             seg;
    int                     lows, idx_int;
    logic                   an_blank, an_ok;
    logic [3:0]             nib;
    logic                   pat_ok;

    assign an  = sync2[W-1:7];
    assign seg = sync2[6:0];

    always_comb begin
        lows    = 0;
        idx_int = 0;
        for (int k = 0; k < SEGMENT_NUM; k++) begin
            if (!an[k]) begin
                lows    = lows + 1;
                idx_int = k;
            end
        end
        an_blank = (lows == 0);
        an_ok    = (lows == 1) && (idx_int < SEGMENT_NUM_USED);
    end

    always_comb begin
        pat_ok = 1'b1;
        nib    = 4'd0;
        case (seg)
            7'b1000000: nib = 4'd0;
            7'b1111001: nib = 4'd1;
            7'b0100100: nib = 4'd2;
            7'b0110000: nib = 4'd3;
            7'b0011001: nib = 4'd4;
            7'b0010010: nib = 4'd5;
            7'b0000010: nib = 4'd6;
            7'b1111000: nib = 4'd7;
            7'b0000000: nib = 4'd8;
            7'b0010000: nib = 4'd9;
            default:    pat_ok = 1'b0;
        endcase
    end

    state_t        state;
    logic [EW-1:0] exp_idx;
    logic [NW-1:0] asm_num, cand, frame_ins;
    logic [MW-1:0] match_cnt, match_nxt;
    logic          take_digit, frame_last, frame_bad;
    int            want_idx;

    always_comb begin
        frame_ins = asm_num;
        for (int k = 0; k < SEGMENT_NUM_USED; k++) begin
            if (k == idx_int)
                frame_ins[4*k +: 4] = nib;
        end
    end

    always_comb begin
        want_idx   = (state == HUNT) ? 0 : int'(exp_idx);
        take_digit = capture && an_ok && pat_ok && (idx_int == want_idx);
        frame_last = (state == HUNT) ? (SEGMENT_NUM_USED == 1)
                                     : (exp_idx == EW'(SEGMENT_NUM_USED - 1));
        // Blank dwells are transparent; anything else unexpected breaks the frame.
        frame_bad  = capture && !an_blank && (state == COLLECT) && !take_digit;
        if (frame_ins != cand)
            match_nxt = MW'(1);
        else if (match_cnt == MW'(FRAMES_TO_MATCH))
            match_nxt = match_cnt;
        else
            match_nxt = match_cnt + MW'(1);
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state         <= HUNT;
            exp_idx       <= '0;
            asm_num       <= '0;
            cand          <= '0;
            match_cnt     <= '0;
            o_BCD_Num     <= '0;
            o_Valid       <= 1'b0;
            o_Locked      <= 1'b0;
            o_Frame_Error <= 1'b0;
        end else begin
            o_Valid       <= 1'b0;
            o_Frame_Error <= 1'b0;
            case (state)
                HUNT: begin
                    if (take_digit) begin
                        asm_num <= frame_ins;
                        if (!frame_last) begin
                            state   <= COLLECT;
                            exp_idx <= EW'(1);
                        end
                    end
                end
                COLLECT: begin
                    if (frame_bad) begin
                        o_Frame_Error <= 1'b1;
                        o_Locked      <= 1'b0;
                        match_cnt     <= '0;
                        state         <= HUNT;
                    end else if (take_digit) begin
                        asm_num <= frame_ins;
                        if (frame_last)
                            state <= HUNT;
                        else
                            exp_idx <= exp_idx + EW'(1);
                    end
                end
                default: state <= HUNT;
            endcase
            if (take_digit && frame_last) begin
                cand      <= frame_ins;
                match_cnt <= match_nxt;
                // A re-confirmed frame already on display stays silent.
                if (match_nxt == MW'(FRAMES_TO_MATCH) &&
                    (!o_Locked || frame_ins != o_BCD_Num)) begin
                    o_BCD_Num <= frame_ins;
                    o_Valid   <= 1'b1;
                    o_Locked  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// tb/tb_seven_segment_scan_decoder.sv - randomized and directed bench for seven_segment_scan_decoder
module tb_seven_segment_scan_decoder;
    localparam int SN = 8;
    localparam int SU = 4;
    localparam int SS = 4;
    localparam int FM = 2;

    logic          i_Clk = 1'b0;
    logic          i_Reset = 1'b0;
    logic [6:0]    i_Segments = 7'h7F;
    logic [SN-1:0] i_Anodes = '1;
    logic [15:0]   o_BCD_Num;
    logic          o_Valid, o_Locked, o_Frame_Error;

    seven_segment_scan_decoder #(
        .SEGMENT_NUM(SN), .SEGMENT_NUM_USED(SU),
        .STABLE_SAMPLES(SS), .FRAMES_TO_MATCH(FM)
    ) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Segments(i_Segments), .i_Anodes(i_Anodes),
        .o_BCD_Num(o_BCD_Num), .o_Valid(o_Valid), .o_Locked(o_Locked),
        .o_Frame_Error(o_Frame_Error)
    );

    always #100 i_Clk = ~i_Clk;

    logic [6:0] lut [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 0;
    int valid_seen = 0;
    int err_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: pin history delayed two clocks, run-length dwell, frame assembly.
    logic [14:0] hist [$] = '{15'h7FFF, 15'h7FFF};
    logic [14:0] ylast = 15'h7FFF;
    int          run = 0;
    bit          m_hunt = 1;
    int          m_exp = 0;
    logic [15:0] m_frame = 0, m_cand = 0, m_bcd = 0;
    int          m_match = 0;
    bit          m_valid = 0, m_locked = 0, m_err = 0;

    function automatic int decode(input logic [6:0] s);
        for (int d = 0; d < 10; d++)
            if (lut[d] == s) return d;
        return -1;
    endfunction

    always @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            hist = '{15'h7FFF, 15'h7FFF};
            ylast = 15'h7FFF; run = 0; m_hunt = 1; m_exp = 0;
            m_frame = 0; m_cand = 0; m_bcd = 0; m_match = 0;
            m_valid = 0; m_locked = 0; m_err = 0;
        end else begin
            logic [14:0] y;
            bit cap;
            m_valid = 0; m_err = 0; cap = 0;
            y = hist.pop_front();
            hist.push_back({i_Anodes, i_Segments});
            if (y != ylast) run = 1;
            else begin
                if (run == SS - 1) cap = 1;
                if (run < SS) run++;
            end
            ylast = y;
            if (cap && y[14:7] != 8'hFF) begin
                int lows, idx, dig;
                bit done;
                lows = 0; idx = -1; done = 0;
                for (int k = 0; k < SN; k++)
                    if (!y[7+k]) begin lows++; idx = k; end
                if (lows != 1 || idx >= SU) idx = -1;
                dig = decode(y[6:0]);
                if (m_hunt) begin
                    if (idx == 0 && dig >= 0) begin
                        m_frame[3:0] = 4'(dig);
                        if (SU == 1) done = 1; else begin m_hunt = 0; m_exp = 1; end
                    end
                end else if (idx == m_exp && dig >= 0) begin
                    m_frame[4*idx +: 4] = 4'(dig);
                    m_exp++;
                    if (m_exp == SU) begin done = 1; m_hunt = 1; end
                end else begin
                    m_err = 1; m_locked = 0; m_match = 0; m_hunt = 1;
                end
                if (done) begin
                    if (m_frame == m_cand) m_match = (m_match < FM) ? m_match + 1 : FM;
                    else begin m_cand = m_frame; m_match = 1; end
                    if (m_match == FM && (!m_locked || m_frame != m_bcd)) begin
                        m_bcd = m_frame; m_valid = 1; m_locked = 1;
                    end
                end
            end
        end
    end

    always @(negedge i_Clk) begin
        if (chk_en) begin
            check("bcd", 32'(o_BCD_Num), 32'(m_bcd));
            check("valid", 32'(o_Valid), 32'(m_valid));
            check("locked", 32'(o_Locked), 32'(m_locked));
            check("frame_error", 32'(o_Frame_Error), 32'(m_err));
            if (o_Valid) valid_seen++;
            if (o_Frame_Error) err_seen++;
        end
    end

    task automatic show(input logic [SN-1:0] an, input logic [6:0] sg, input int n);
        repeat (n) begin
            i_Anodes = an;
            i_Segments = sg;
            @(negedge i_Clk);
        end
    endtask

    function automatic logic [SN-1:0] dig_an(input int k);
        logic [SN-1:0] one;
        one = 1;
        return ~(one << k);
    endfunction

    task automatic scan(input logic [15:0] num, input int dwell, input bit blanks);
        for (int k = 0; k < SU; k++) begin
            show(dig_an(k), lut[num[4*k +: 4]], dwell);
            if (blanks) show('1, 7'h7F, dwell);
        end
    endtask

    initial begin
        int v0, e0;
        repeat (3) @(negedge i_Clk);
        i_Reset = 1'b1;
        chk_en = 1;
        check("reset_bcd", 32'(o_BCD_Num), 32'h0);
        check("reset_flags", {29'd0, o_Valid, o_Locked, o_Frame_Error}, 32'h0);

        scan(16'h4321, 10, 0);
        check("first_frame_no_valid", valid_seen, 0);
        scan(16'h4321, 10, 0);
        check("valid_after_two", valid_seen, 1);
        check("bcd_4321", 32'(o_BCD_Num), 32'h4321);
        check("locked_4321", 32'(o_Locked), 32'h1);

        repeat (5) scan(16'h4321, 10, 0);
        check("repeat_no_valid", valid_seen, 1);
        check("repeat_no_err", err_seen, 0);
        scan(16'h1259, 10, 0);
        scan(16'h1259, 10, 0);
        check("switch_valid", valid_seen, 2);
        check("bcd_1259", 32'(o_BCD_Num), 32'h1259);

        show(dig_an(0), lut[9], 10);
        show(dig_an(2), lut[2], 10);
        check("order_err", err_seen, 1);
        check("order_unlock", 32'(o_Locked), 32'h0);
        show(dig_an(1), lut[5], 10);
        show(dig_an(3), lut[1], 10);
        check("order_hold_bcd", 32'(o_BCD_Num), 32'h1259);
        check("order_single_err", err_seen, 1);
        scan(16'h1259, 10, 0);
        scan(16'h1259, 10, 0);
        check("recover_valid", valid_seen, 3);
        check("recover_locked", 32'(o_Locked), 32'h1);

        show(dig_an(0), lut[9], 10);
        show(dig_an(1), 7'b0000110, 10);
        check("pattern_E_err", err_seen, 2);
        show(dig_an(0), lut[9], 10);
        show(8'b11111100, lut[5], 10);
        check("two_anodes_err", err_seen, 3);
        v0 = valid_seen; e0 = err_seen;
        scan(16'h8076, 10, 1);
        scan(16'h8076, 10, 1);
        check("blank_no_err", err_seen, e0);
        check("blank_valid", valid_seen, v0 + 1);
        check("bcd_8076", 32'(o_BCD_Num), 32'h8076);

        show(dig_an(0), lut[6], 10);
        show(dig_an(1), lut[7], 2);
        show(dig_an(2), lut[3], 3);
        show(dig_an(1), lut[7], 8);
        show(dig_an(2), lut[0], 10);
        show(dig_an(3), lut[8], 10);
        check("glitch_no_err", err_seen, e0);

        show(dig_an(0), lut[4], 10);
        show(dig_an(1), lut[4], 5);
        #2 i_Reset = 1'b0;
        #1;
        check("midreset_bcd", 32'(o_BCD_Num), 32'h0);
        check("midreset_flags", {29'd0, o_Valid, o_Locked, o_Frame_Error}, 32'h0);
        @(negedge i_Clk);
        @(negedge i_Clk);
        i_Reset = 1'b1;
        v0 = valid_seen;
        scan(16'h9305, 10, 0);
        scan(16'h9305, 10, 0);
        check("post_reset_valid", valid_seen, v0 + 1);
        check("post_reset_bcd", 32'(o_BCD_Num), 32'h9305);

        for (int f = 0; f < 150; f++) begin
            logic [15:0] num;
            int reps;
            for (int k = 0; k < SU; k++) num[4*k +: 4] = 4'($urandom_range(0, 9));
            reps = $urandom_range(1, 3);
            repeat (reps) begin
                for (int k = 0; k < SU; k++) begin
                    int r;
                    r = $urandom_range(0, 39);
                    if (r == 0) show(SN'($urandom), 7'($urandom), $urandom_range(1, 8));
                    if (r == 2) show(dig_an($urandom_range(0, SN - 1)), lut[$urandom_range(0, 9)], 3);
                    if (r == 3) show('1, 7'h7F, $urandom_range(1, 8));
                    show(dig_an(k), lut[num[4*k +: 4]],
                         (r == 1) ? $urandom_range(1, 3) : $urandom_range(4, 12));
                end
            end
        end
        show('1, 7'h7F, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/seven_segment_scan_decoder.md
# seven_segment_scan_decoder

Receive-side counterpart of the seven-segment display driver. It samples the multiplexed segment and anode lines, decodes each scanned digit back to BCD, checks scan order and pattern validity, and presents a confirmed packed BCD number. It is used as an on-chip readback monitor of the alarm clock display and as a self-checking element in system benches.

## Interface
- SEGMENT_NUM, 8, number of anode lines sampled.
- SEGMENT_NUM_USED, 4, digits assembled into the output; must be ≥1 and ≤SEGMENT_NUM.
- STABLE_SAMPLES, 4, consecutive identical synchronized samples required before a digit is captured; must be ≥2.
- FRAMES_TO_MATCH, 2, consecutive identical complete frames required before the output updates; must be ≥1.
- i_Clk  in  1  system clock (5 MHz domain).
- i_Reset  in  1  asynchronous, active-low reset.
- i_Segments  in  7  segment lines, active-low; bit 0 = a … bit 6 = g.
- i_Anodes  in  SEGMENT_NUM  anode lines, active-low; bit k selects digit k.
- o_BCD_Num  out  4*SEGMENT_NUM_USED  confirmed number; digit k occupies bits [4k+3:4k].
- o_Valid  out  1  one-cycle pulse when o_BCD_Num loads.
- o_Locked  out  1  high while o_BCD_Num reflects a confirmed frame and no error has occurred since.
- o_Frame_Error  out  1  one-cycle pulse on any scan or pattern error.

## Operation
- Input capture: i_Segments and i_Anodes pass through a two-flop synchronizer. All logic below acts on the synchronized values.
- Dwell counter:
  - Resets to 1 whenever the synchronized {anodes, segments} differs from the previous cycle.
  - Otherwise increments, saturating at STABLE_SAMPLES.
  - A capture event fires on the cycle the counter first equals STABLE_SAMPLES, so there is exactly one capture per dwell.
- Anode classification at capture:
  - All high: blank. The dwell is ignored; no error and no state change.
  - Exactly one low bit k with k < SEGMENT_NUM_USED: digit k.
  - Anything else (multiple lows, or k ≥ SEGMENT_NUM_USED): error.
- Pattern decode (active-low, gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any other pattern is an error.
- Frame FSM:
  - HUNT: a digit-0 capture with a valid pattern stores nibble 0. If SEGMENT_NUM_USED=1 the frame completes; otherwise go to COLLECT with expected index 1. Other captures are ignored without error.
  - COLLECT: a capture of the expected index with a valid pattern stores the nibble and increments the expected index. Capturing index SEGMENT_NUM_USED-1 completes the frame and returns to HUNT. A wrong index, invalid pattern, or error anode pulses o_Frame_Error, clears o_Locked, clears the match count, and returns to HUNT.
  - A re-capture of the same index in COLLECT is an error.
- Frame completion:
  - If the assembled frame equals the candidate register, the match count increments, saturating at FRAMES_TO_MATCH.
  - Otherwise the candidate is set to the frame and the match count is set to 1.
  - When the match count reaches FRAMES_TO_MATCH on this completion (including FRAMES_TO_MATCH=1):
    - If o_Locked=0 or the frame differs from o_BCD_Num: load o_BCD_Num, pulse o_Valid, set o_Locked.
    - Otherwise: no pulse; o_Locked stays high.
- Reset (asynchronous, any time): FSM=HUNT, synchronizer flops = all ones (blank), dwell counter=0, candidate=0, match count=0, o_BCD_Num=0, o_Valid=0, o_Locked=0, o_Frame_Error=0. An in-progress frame is discarded.

## Timing
- Input-to-capture latency: 2 (synchronizer) + STABLE_SAMPLES − 1 cycles after the pins settle.
- The cycle after the completing capture: o_Valid (if loading) and the new o_BCD_Num are visible together.
- The cycle after the erroring capture: o_Frame_Error is high for 1 cycle and o_Locked falls.
- Simultaneous events cannot occur: only one capture can happen per cycle. An error and a completion never coincide.
- Dwells shorter than STABLE_SAMPLES are invisible to the decoder (glitch rejection).

## Test plan
- After reset: o_BCD_Num=0x0000 and all flags 0. Scan 1,2,3,4 on digits 0..3 (anodes 1110,1101,1011,0111; dwell 10 cycles; FRAMES_TO_MATCH=2) → o_Valid is a single pulse after the second frame, o_BCD_Num=0x4321, o_Locked=1.
- Repeat 0x4321 frames 5 times → no further o_Valid and no errors. Switch to 0x1259 → exactly one o_Valid after the second 0x1259 frame.
- Scan order 0,2,1,3 → o_Frame_Error pulses on the digit-2 capture, o_Locked=0, o_BCD_Num holds 0x1259. Recovery with 2 good frames of 0x1259 → o_Valid, o_Locked=1.
- Segment pattern 0000110 ('E') on digit 1 → o_Frame_Error. Two anodes low (1100) → o_Frame_Error. All-high blank dwells between digits → ignored, no error.
- 3-cycle glitch to a different digit mid-dwell → no capture, no error. Assert i_Reset low mid-frame → all outputs 0 immediately, and the next complete matching frames decode normally.
